// File: rtl/uart_program_loader_if.sv
// Memory write port driven by the UART program loader.
// One-cycle write strobe with word address and data.
interface uart_program_loader_if #(
    parameter int ADDR_W = 15
) ();
    logic              prog_we_o;
    logic [ADDR_W-1:0] prog_addr_o;
    logic [31:0]       prog_wdata_o;

    modport master (
        output prog_we_o,
        output prog_addr_o,
        output prog_wdata_o
    );

    modport slave (
        input prog_we_o,
        input prog_addr_o,
        input prog_wdata_o
    );
endinterface

// File: rtl/uart_program_loader.sv
// UART program loader: MAGIC, 32-bit LE length, LE words into RAM.
// Holds the core in reset while a frame is being received.
module uart_program_loader #(
    parameter int          CLK_HZ       = 60_000_000,
    parameter int          BAUD         = 115200,
    parameter int          CLKS_PER_BIT = CLK_HZ / BAUD,
    parameter int          RAM_DEPTH    = 'h5000,
    parameter int          ADDR_W       = $clog2(RAM_DEPTH),
    parameter logic [31:0] MAGIC        = 32'h5445_4B4E,
    parameter int          TIMEOUT_CLKS = 60_000_000
) (
    input  logic                  clk_wiz_o,
    input  logic                  rst_n,
    input  logic                  prog_rx_i,
    uart_program_loader_if.master prog_bus,
    output logic                  system_reset_o,
    output logic                  prog_mode_led_o,
    output logic                  err_o
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        L_IDLE, L_LEN, L_DATA
    } ld_state_e;

    logic            r_rx_meta;
    logic            r_rx_sync;
    rx_state_e       r_rx_state, w_rx_state_nxt;
    logic [CW-1:0]   r_clk_cnt, w_clk_cnt_nxt;
    logic [2:0]      r_bit_idx, w_bit_idx_nxt;
    logic [7:0]      r_rx_shift, w_rx_shift_nxt;
    logic            r_byte_valid, w_byte_valid_nxt;
    logic            r_rx_err, w_rx_err_nxt;

    ld_state_e         r_ld_state, w_ld_state_nxt;
    logic [31:0]       r_magic, w_magic_nxt;
    logic [31:0]       r_len, w_len_nxt;
    logic [31:0]       r_word, w_word_nxt;
    logic [1:0]        r_byte_cnt, w_byte_cnt_nxt;
    logic [31:0]       r_word_cnt, w_word_cnt_nxt;
    logic [TW-1:0]     r_tmo, w_tmo_nxt;
    logic              r_word_done, w_word_done_nxt;
    logic              r_ovf_seen, w_ovf_seen_nxt;
    logic              r_we, w_we_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [31:0]       r_wdata, w_wdata_nxt;
    logic              r_sys_rst, r_led;
    logic              r_err, w_err_nxt;

    logic [31:0] w_magic_sh;
    logic [31:0] w_len_sh;
    logic [31:0] w_word_sh;
    logic [31:0] w_cnt_inc;

    assign w_magic_sh = {r_magic[23:0], r_rx_shift};
    assign w_len_sh   = {r_rx_shift, r_len[31:8]};
    assign w_word_sh  = {r_rx_shift, r_word[31:8]};
    assign w_cnt_inc  = r_word_cnt + 32'd1;

    assign prog_bus.prog_we_o    = r_we;
    assign prog_bus.prog_addr_o  = r_addr;
    assign prog_bus.prog_wdata_o = r_wdata;
    assign system_reset_o        = r_sys_rst;
    assign prog_mode_led_o       = r_led;
    assign err_o                 = r_err;

    always_ff @(posedge clk_wiz_o) begin
        if (!rst_n) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_state   <= RX_IDLE;
            r_clk_cnt    <= '0;
            r_bit_idx    <= '0;
            r_rx_shift   <= '0;
            r_byte_valid <= 1'b0;
            r_rx_err     <= 1'b0;
        end else begin
            r_rx_meta    <= prog_rx_i;
            r_rx_sync    <= r_rx_meta;
            r_rx_state   <= w_rx_state_nxt;
            r_clk_cnt    <= w_clk_cnt_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_rx_shift   <= w_rx_shift_nxt;
            r_byte_valid <= w_byte_valid_nxt;
            r_rx_err     <= w_rx_err_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt   = r_rx_state;
        w_clk_cnt_nxt    = r_clk_cnt;
        w_bit_idx_nxt    = r_bit_idx;
        w_rx_shift_nxt   = r_rx_shift;
        w_byte_valid_nxt = 1'b0;
        w_rx_err_nxt     = 1'b0;
        unique case (r_rx_state)
            RX_IDLE: begin
                w_clk_cnt_nxt = '0;
                if (!r_rx_sync)
                    w_rx_state_nxt = RX_START;
            end
            RX_START: begin
                if (r_clk_cnt == C_HALF) begin
                    w_clk_cnt_nxt  = '0;
                    w_bit_idx_nxt  = '0;
                    w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (r_clk_cnt == C_LAST) begin
                    w_clk_cnt_nxt  = '0;
                    w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
                    w_bit_idx_nxt  = r_bit_idx + 1'b1;
                    if (r_bit_idx == 3'd7)
                        w_rx_state_nxt = RX_STOP;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (r_clk_cnt == C_LAST) begin
                    w_clk_cnt_nxt    = '0;
                    w_rx_state_nxt   = RX_IDLE;
                    w_byte_valid_nxt = r_rx_sync;
                    w_rx_err_nxt     = !r_rx_sync;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + 1'b1;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_wiz_o) begin
        if (!rst_n) begin
            r_ld_state  <= L_IDLE;
            r_magic     <= '0;
            r_len       <= '0;
            r_word      <= '0;
            r_byte_cnt  <= '0;
            r_word_cnt  <= '0;
            r_tmo       <= '0;
            r_word_done <= 1'b0;
            r_ovf_seen  <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_sys_rst   <= 1'b1;
            r_led       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ld_state  <= w_ld_state_nxt;
            r_magic     <= w_magic_nxt;
            r_len       <= w_len_nxt;
            r_word      <= w_word_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_word_cnt  <= w_word_cnt_nxt;
            r_tmo       <= w_tmo_nxt;
            r_word_done <= w_word_done_nxt;
            r_ovf_seen  <= w_ovf_seen_nxt;
            r_we        <= w_we_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_sys_rst   <= (w_ld_state_nxt == L_IDLE);
            r_led       <= (w_ld_state_nxt != L_IDLE);
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_ld_state_nxt  = r_ld_state;
        w_magic_nxt     = r_magic;
        w_len_nxt       = r_len;
        w_word_nxt      = r_word;
        w_byte_cnt_nxt  = r_byte_cnt;
        w_word_cnt_nxt  = r_word_cnt;
        w_tmo_nxt       = r_tmo;
        w_word_done_nxt = 1'b0;
        w_ovf_seen_nxt  = r_ovf_seen;
        w_we_nxt        = 1'b0;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_err_nxt       = r_rx_err;
        unique case (r_ld_state)
            L_IDLE: begin
                if (r_byte_valid) begin
                    if (w_magic_sh == MAGIC) begin
                        w_ld_state_nxt = L_LEN;
                        w_magic_nxt    = '0;
                        w_len_nxt      = '0;
                        w_byte_cnt_nxt = '0;
                        w_word_cnt_nxt = '0;
                        w_tmo_nxt      = '0;
                        w_ovf_seen_nxt = 1'b0;
                    end else begin
                        w_magic_nxt = w_magic_sh;
                    end
                end
            end
            L_LEN: begin
                w_magic_nxt = '0;
                if (r_byte_valid) begin
                    w_tmo_nxt      = '0;
                    w_len_nxt      = w_len_sh;
                    w_byte_cnt_nxt = r_byte_cnt + 1'b1;
                    if (r_byte_cnt == 2'd3) begin
                        w_word_cnt_nxt = '0;
                        w_addr_nxt     = '0;
                        w_ld_state_nxt = (w_len_sh == 32'd0) ? L_IDLE : L_DATA;
                    end
                end else if (r_tmo == T_LAST) begin
                    w_ld_state_nxt = L_IDLE;
                    w_err_nxt      = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            L_DATA: begin
                w_magic_nxt = '0;
                if (r_byte_valid) begin
                    w_tmo_nxt      = '0;
                    w_word_nxt     = w_word_sh;
                    w_byte_cnt_nxt = r_byte_cnt + 1'b1;
                    if (r_byte_cnt == 2'd3) begin
                        w_word_done_nxt = 1'b1;
                        // Out-of-range words are swallowed; flag only the first.
                        if (r_word_cnt < 32'(RAM_DEPTH)) begin
                            w_we_nxt    = 1'b1;
                            w_wdata_nxt = w_word_sh;
                        end else if (!r_ovf_seen) begin
                            w_err_nxt      = 1'b1;
                            w_ovf_seen_nxt = 1'b1;
                        end
                    end
                end else if (r_tmo == T_LAST) begin
                    w_ld_state_nxt = L_IDLE;
                    w_err_nxt      = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
                if (r_word_done) begin
                    w_word_cnt_nxt = w_cnt_inc;
                    w_addr_nxt     = w_cnt_inc[ADDR_W-1:0];
                    if (w_cnt_inc == r_len)
                        w_ld_state_nxt = L_IDLE;
                end
            end
            default: w_ld_state_nxt = L_IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: frame table plus
// idle, timeout and mid-download reset sequences.
module tb_uart_program_loader;
    localparam int CPB     = 8;
    localparam int TMO     = 2000;
    localparam int DEPTH   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic sys_rst, led, err;

    always #5 clk = ~clk;

    uart_program_loader_if #(.ADDR_W(2)) bus ();

    uart_program_loader #(
        .CLK_HZ(1_000_000),
        .BAUD(125_000),
        .RAM_DEPTH(DEPTH),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk_wiz_o(clk),
        .rst_n(rst_n),
        .prog_rx_i(rx),
        .prog_bus(bus),
        .system_reset_o(sys_rst),
        .prog_mode_led_o(led),
        .err_o(err)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int err_cnt, last_we_cyc, rise_cyc, last_err_cyc, we_out_of_dl;
    bit saw_low, prev_sys;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.prog_we_o) begin
                wr_addr_q.push_back(int'(bus.prog_addr_o));
                wr_data_q.push_back(bus.prog_wdata_o);
                last_we_cyc = cyc;
                if (sys_rst || !led)
                    we_out_of_dl++;
            end
            if (err) begin
                err_cnt++;
                last_err_cyc = cyc;
            end
            if (!sys_rst)
                saw_low = 1'b1;
            if (sys_rst && !prev_sys)
                rise_cyc = cyc;
            prev_sys = sys_rst;
        end
    end

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        err_cnt = 0;
        last_we_cyc = -1;
        rise_cyc = -1;
        last_err_cyc = -1;
        saw_low = 1'b0;
        prev_sys = sys_rst;
    endtask

    task automatic check(input string name, input longint act,
                         input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = !bad_stop;
        tick(CPB);
        rx = 1'b1;
        if (bad_stop)
            tick(2 * CPB);
    endtask

    task automatic send_le(input logic [31:0] w);
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8], 1'b0);
    endtask

    task automatic send_magic();
        send_byte(8'h54, 1'b0);
        send_byte(8'h45, 1'b0);
        send_byte(8'h4B, 1'b0);
        send_byte(8'h4E, 1'b0);
    endtask

    typedef struct {
        string       name;
        logic        bad_first;
        logic [31:0] len;
        int          nsent;
        logic [31:0] wd[6];
        int          exp_nwr;
        int          exp_err;
        logic        chk_rel;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"two_words", 1'b0, 32'd2, 2,
                    '{32'h13, 32'h6F, 0, 0, 0, 0}, 2, 0, 1'b1};
        vecs[1] = '{"zero_len", 1'b0, 32'd0, 0,
                    '{0, 0, 0, 0, 0, 0}, 0, 0, 1'b0};
        vecs[2] = '{"bad_stop_first", 1'b1, 32'd1, 1,
                    '{32'hA5A5_1234, 0, 0, 0, 0, 0}, 1, 1, 1'b1};
        vecs[3] = '{"overflow", 1'b0, 32'd5, 5,
                    '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                      32'h4444_4444, 32'h5555_5555, 0}, 4, 1, 1'b0};
        vecs[4] = '{"full_depth", 1'b0, 32'd4, 4,
                    '{32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002,
                      32'hCAFE_0003, 0, 0}, 4, 0, 1'b1};
        vecs[5] = '{"magic_in_payload", 1'b0, 32'd2, 2,
                    '{32'h4E4B_4554, 32'hDEAD_BEEF, 0, 0, 0, 0},
                    2, 0, 1'b1};

        we_out_of_dl = 0;
        tick(3);
        check("rst_we", bus.prog_we_o, 0);
        check("rst_addr", bus.prog_addr_o, 0);
        check("rst_wdata", bus.prog_wdata_o, 0);
        check("rst_sys", sys_rst, 1);
        check("rst_led", led, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        clear_mon();
        tick(10_000);
        check("idle_writes", wr_addr_q.size(), 0);
        check("idle_errs", err_cnt, 0);
        check("idle_sys_low", saw_low, 0);

        for (int v = 0; v < 6; v++) begin
            clear_mon();
            if (vecs[v].bad_first)
                send_byte(8'h54, 1'b1);
            send_magic();
            send_le(vecs[v].len);
            for (int k = 0; k < vecs[v].nsent; k++)
                send_le(vecs[v].wd[k]);
            tick(40);
            check({vecs[v].name, "_nwr"}, wr_addr_q.size(),
                  vecs[v].exp_nwr);
            for (int i = 0; i < vecs[v].exp_nwr; i++) begin
                if (i < wr_addr_q.size()) begin
                    check({vecs[v].name, "_addr"}, wr_addr_q[i], i);
                    check({vecs[v].name, "_data"}, wr_data_q[i],
                          vecs[v].wd[i]);
                end
            end
            check({vecs[v].name, "_err"}, err_cnt, vecs[v].exp_err);
            check({vecs[v].name, "_busy"}, saw_low, 1);
            check({vecs[v].name, "_sys_end"}, sys_rst, 1);
            check({vecs[v].name, "_led_end"}, led, 0);
            if (vecs[v].chk_rel)
                check({vecs[v].name, "_release"}, rise_cyc,
                      last_we_cyc + 1);
        end

        // Stalled frame: length 3, only five data bytes.
        clear_mon();
        send_magic();
        send_le(32'd3);
        send_le(32'h0BAD_F00D);
        send_byte(8'h77, 1'b0);
        begin
            int t0;
            int n;
            t0 = cyc;
            n = 0;
            while (err_cnt == 0 && n < TMO + 200) begin
                tick(1);
                n++;
            end
            check("tmo_seen", err_cnt, 1);
            check("tmo_window",
                  (last_err_cyc - t0 >= TMO - 16) &&
                  (last_err_cyc - t0 <= TMO + 16), 1);
        end
        tick(5);
        check("tmo_nwr", wr_addr_q.size(), 1);
        if (wr_addr_q.size() > 0) begin
            check("tmo_addr", wr_addr_q[0], 0);
            check("tmo_data", wr_data_q[0], 32'h0BAD_F00D);
        end
        check("tmo_sys", sys_rst, 1);
        check("tmo_led", led, 0);

        // Reset in the middle of a download forces a fresh MAGIC.
        clear_mon();
        send_magic();
        send_le(32'd2);
        send_le(32'h1234_5678);
        tick(5);
        check("mid_nwr", wr_addr_q.size(), 1);
        check("mid_busy", sys_rst, 0);
        rst_n = 1'b0;
        tick(2);
        check("mid_rst_sys", sys_rst, 1);
        check("mid_rst_led", led, 0);
        check("mid_rst_addr", bus.prog_addr_o, 0);
        check("mid_rst_wdata", bus.prog_wdata_o, 0);
        rst_n = 1'b1;
        tick(2);
        clear_mon();
        send_le(32'h9ABC_DEF0);
        send_le(32'h0000_0001);
        tick(40);
        check("post_rst_nwr", wr_addr_q.size(), 0);
        check("post_rst_low", saw_low, 0);

        check("we_outside_dl", we_out_of_dl, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
